// File: rtl/ram_dump_pkg.sv
// ram_dump_pkg: shared FSM states, ASCII constants and nibble encoder for the hex dumper.
package ram_dump_pkg;
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, WAIT_TX, NEXT, DONE} state_t;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int BYTES_PER_WORD = 6;
    function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/ram_hex_dump_uart_if.sv
// ram_hex_dump_uart_if: read port between the dumper and its output RAM.
interface ram_hex_dump_uart_if;
    logic        read_enable_to_ram;
    logic [5:0]  address_to_ram;
    logic [15:0] data_from_ram;
    modport master(output read_enable_to_ram, output address_to_ram, input data_from_ram);
    modport slave(input read_enable_to_ram, input address_to_ram, output data_from_ram);
endinterface

// File: rtl/ram_hex_dump_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready only while idle, so one byte is in flight at a time.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          active;
    assign tx_ready = !active;
    // shreg holds the remaining data bits with the stop bit on top
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx  <= 1'b1;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (!active) begin
            if (tx_valid) begin
                shreg    <= {1'b1, tx_data};
                uart_tx  <= 1'b0;
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
            end else begin
                uart_tx <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + BW'(1);
        end
    end
endmodule

// File: rtl/ram_hex_dump_uart.sv
// ram_hex_dump_uart: reads WORD_COUNT RAM words and prints each as "HHHH\r\n" over UART.
module ram_hex_dump_uart
    import ram_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_COUNT   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    ram_hex_dump_uart_if.master        ram,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       done
);
    state_t      state;
    logic [15:0] word;
    logic [2:0]  byte_idx;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_byte;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    // word is shifted left per nibble, so the next nibble is always in [15:12]
    assign nxt_idx  = byte_idx + 3'd1;
    assign nxt_byte = nxt_idx < 3'd4 ? nibble_ascii(word[15:12]) : nxt_idx == 3'd4 ? ASCII_CR : ASCII_LF;
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            ram.read_enable_to_ram <= 1'b0;
            ram.address_to_ram     <= '0;
            word                   <= '0;
            byte_idx               <= '0;
            tx_data                <= '0;
            tx_valid               <= 1'b0;
        end else begin
            ram.read_enable_to_ram <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ram.address_to_ram     <= '0;
                    ram.read_enable_to_ram <= 1'b1;
                    busy                   <= 1'b1;
                    state                  <= READ;
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    word     <= {ram.data_from_ram[11:0], 4'h0};
                    tx_data  <= nibble_ascii(ram.data_from_ram[15:12]);
                    tx_valid <= 1'b1;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: if (tx_ready) begin
                    if (byte_idx == 3'(BYTES_PER_WORD - 1)) begin
                        state <= NEXT;
                    end else begin
                        byte_idx <= nxt_idx;
                        tx_data  <= nxt_byte;
                        word     <= {word[11:0], 4'h0};
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                NEXT: if (ram.address_to_ram == 6'(WORD_COUNT - 1)) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    ram.address_to_ram     <= ram.address_to_ram + 6'd1;
                    ram.read_enable_to_ram <= 1'b1;
                    state                  <= READ;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .uart_tx (uart_tx)
    );
endmodule

// File: tb/tb_ram_hex_dump_uart.sv
// tb_ram_hex_dump_uart: one-word and 64-word dumpers checked against a hex-line model.
module tb_ram_hex_dump_uart;
    localparam int CPB = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v [2];
    logic        tx [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic [15:0] mem [64];
    logic [7:0]  rxq [2][$];
    logic [7:0]  exp_q [$];
    logic [5:0]  addr_log [$];
    int          ndone [2];
    int          n_cmp = 0;
    int          n_err = 0;
    string       hexs = "0123456789ABCDEF";

    always #5 clk = ~clk;

    ram_hex_dump_uart_if bus0 ();
    ram_hex_dump_uart_if bus1 ();

    ram_hex_dump_uart #(.CLKS_PER_BIT(CPB), .WORD_COUNT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .ram(bus0),
        .uart_tx(tx[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    ram_hex_dump_uart #(.CLKS_PER_BIT(CPB), .WORD_COUNT(64)) dut64 (
        .clk(clk), .reset(reset), .start(start_v[1]), .ram(bus1),
        .uart_tx(tx[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    always @(posedge clk) begin
        if (bus0.read_enable_to_ram) bus0.data_from_ram <= mem[bus0.address_to_ram];
        if (bus1.read_enable_to_ram) bus1.data_from_ram <= mem[bus1.address_to_ram];
        if (bus1.read_enable_to_ram && !reset) addr_log.push_back(bus1.address_to_ram);
    end

    always @(negedge clk) begin
        if (done_v[0] === 1'b1) ndone[0]++;
        if (done_v[1] === 1'b1) ndone[1]++;
    end

    for (genvar g = 0; g < 2; g++) begin : g_rx
        initial begin
            logic [7:0] b;
            forever begin
                @(negedge clk);
                if (!reset && tx[g] === 1'b0) begin
                    repeat (CPB / 2) @(negedge clk);
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) @(negedge clk);
                        b[k] = tx[g];
                    end
                    repeat (CPB) @(negedge clk);
                    rxq[g].push_back(b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: each word becomes four uppercase hex characters, CR, LF
    function automatic void build_model(input int wc);
        exp_q.delete();
        for (int w = 0; w < wc; w++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(hexs[(mem[w] >> (12 - 4 * k)) & 16'hF]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic compare_bytes(input int g, input string tag);
        check({tag, "_nbytes"}, 64'(rxq[g].size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rxq[g].size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(rxq[g][i]), 64'(exp_q[i]));
    endtask

    task automatic pulse(input int g);
        @(negedge clk) start_v[g] = 1'b1;
        @(negedge clk) start_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget, input string tag);
        int i = 0;
        while (busy_v[g] !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_timeout"}, 64'(i < budget), 64'd1);
    endtask

    task automatic wait_low(input int g, input string tag);
        int i = 0;
        while (tx[g] !== 1'b0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_frame_timeout"}, 64'(i < 500), 64'd1);
    endtask

    initial begin
        int lat;
        logic idle_low;
        logic [39:0] got_f, exp_f;
        logic [9:0] frame;
        logic got_done;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_tx%0d", g), 64'(tx[g]), 64'd1);
            check($sformatf("rst_busy%0d", g), 64'(busy_v[g]), 64'd0);
            check($sformatf("rst_done%0d", g), 64'(done_v[g]), 64'd0);
        end
        check("rst_re", 64'(bus1.read_enable_to_ram), 64'd0);
        check("rst_addr", 64'(bus1.address_to_ram), 64'd0);
        reset = 1'b0;
        idle_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || tx[1] !== 1'b1) idle_low = 1'b1;
        end
        check("idle_no_frames", 64'(idle_low), 64'd0);
        check("idle_rx_empty", 64'(rxq[0].size() + rxq[1].size()), 64'd0);

        // single word: latency, exact first frame shape, full line
        mem[0] = 16'h1A2F;
        build_model(1);
        ndone[0] = 0;
        pulse(0);
        lat = 0;
        while (tx[0] === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency_le5", 64'(lat <= 5), 64'd1);
        frame = {1'b1, exp_q[0], 1'b0};
        for (int i = 0; i < 40; i++) begin
            got_f[i] = tx[0];
            exp_f[i] = frame[i / CPB];
            @(negedge clk);
        end
        check("frame_shape_0x31", 64'(got_f), 64'(exp_f));
        wait_idle(0, 2000, "w1");
        repeat (10) @(negedge clk);
        compare_bytes(0, "w1");
        check("w1_done_pulses", 64'(ndone[0]), 64'd1);
        check("w1_busy_end", 64'(busy_v[0]), 64'd0);

        // 64 words with start re-pulsed mid-run and on the done cycle
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0101);
        build_model(64);
        rxq[1].delete();
        addr_log.delete();
        ndone[1] = 0;
        got_done = 1'b0;
        pulse(1);
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (i == 1000) check("w64_busy_mid", 64'(busy_v[1]), 64'd1);
            start_v[1] = (i == 1000) || (done_v[1] === 1'b1);
            if (done_v[1] === 1'b1) begin
                got_done = 1'b1;
                @(negedge clk);
                start_v[1] = 1'b0;
                break;
            end
        end
        check("w64_done_seen", 64'(got_done), 64'd1);
        repeat (200) @(negedge clk);
        check("w64_busy_after", 64'(busy_v[1]), 64'd0);
        check("w64_done_pulses", 64'(ndone[1]), 64'd1);
        compare_bytes(1, "w64");
        check("w64_nreads", 64'(addr_log.size()), 64'd64);
        for (int i = 0; i < addr_log.size(); i++) check($sformatf("w64_addr%0d", i), 64'(addr_log[i]), 64'(i));

        // reset during data bit 3 of the second frame, then a clean random dump
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        build_model(64);
        pulse(1);
        wait_low(1, "rst1");
        repeat (10 * CPB) @(negedge clk);
        wait_low(1, "rst2");
        repeat (4 * CPB + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", 64'(tx[1]), 64'd1);
        check("midrst_busy", 64'(busy_v[1]), 64'd0);
        check("midrst_re", 64'(bus1.read_enable_to_ram), 64'd0);
        check("midrst_addr", 64'(bus1.address_to_ram), 64'd0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        rxq[1].delete();
        addr_log.delete();
        pulse(1);
        wait_idle(1, 25000, "rnd");
        repeat (10) @(negedge clk);
        check("rnd_first_byte", 64'(rxq[1].size() > 0 ? rxq[1][0] : 8'h00), 64'(exp_q[0]));
        compare_bytes(1, "rnd");
        check("rnd_nreads", 64'(addr_log.size()), 64'd64);
        check("rnd_first_addr", 64'(addr_log.size() > 0 ? addr_log[0] : 6'h3F), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
